// File: rtl/ppc_seg_pkg.sv
// rtl/ppc_seg_pkg.sv - shared glyph constants and digit-index type for the ping-pong counter display
package ppc_seg_pkg;

   // Glyphs are active-low, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_UP    = 7'b1011100;
   localparam logic [6:0] SEG_DOWN  = 7'b1100011;

   // Decimal digit glyphs; element [n] is the glyph for n
   localparam logic [9:0][6:0] DIGIT_GLYPH = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Scan position, rightmost digit first
   typedef enum logic [1:0] {
      ONES  = 2'd0,
      TENS  = 2'd1,
      DIR_L = 2'd2,
      DIR_H = 2'd3
   } digit_idx_t;

endpackage

// File: rtl/ppc_seg_display_if.sv
// rtl/ppc_seg_display_if.sv - counter-to-display bundle: value/direction in, digit drive out
interface ppc_seg_display_if;
   logic [3:0] out_val;
   logic       direction;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (output out_val, output direction, input an, input seg, input dp);
   modport slave  (input out_val, input direction, output an, output seg, output dp);
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to active-low 7-segment glyph
module seg7_decoder
   import ppc_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Non-decimal codes map to blank so no illegal pattern can reach the pins
   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) begin
         seg = DIGIT_GLYPH[bcd];
      end
   end

endmodule

// File: rtl/ppc_seg_display.sv
// rtl/ppc_seg_display.sv - 4-digit multiplexed display of counter value and direction (option: PPC_SEG_LEADING_ZERO_EN)
module ppc_seg_display
   import ppc_seg_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int DIV_W    = 17
)
(
   input  logic               clk,
   input  logic               rst,
   ppc_seg_display_if.slave   bus
);

   logic [DIV_W-1:0] div;
   digit_idx_t       idx;
   logic             prime;
   logic [3:0]       shadow_val;
   logic             shadow_dir;
   logic             wrap;
   logic             capture;
   logic             tens;
   logic [3:0]       dec_in;
   logic [6:0]       dec_seg;
   logic [6:0]       seg_next;
   logic [3:0]       an_q;
   logic [6:0]       seg_q;

   assign wrap    = (div == DIV_W'(SCAN_DIV - 1));
   // Capture only at frame boundaries so a frame never mixes two values
   assign capture = prime || (wrap && (idx == DIR_H));
   assign tens    = (shadow_val >= 4'd10);

   // Scan divider and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
         idx <= ONES;
      end else if (wrap) begin
         div <= '0;
         idx <= digit_idx_t'(idx + 2'd1);
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // Frame shadow of the counter inputs; prime forces a capture right after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prime      <= 1'b1;
         shadow_val <= 4'd0;
         shadow_dir <= 1'b1;
      end else begin
         prime <= 1'b0;
         if (capture) begin
            shadow_val <= bus.out_val;
            shadow_dir <= bus.direction;
         end
      end
   end

   // Select the decimal digit that the current scan position needs
   always_comb begin
      dec_in = 4'd0;
      case (idx)
         ONES:    dec_in = tens ? (shadow_val - 4'd10) : shadow_val;
         TENS:    dec_in = {3'b000, tens};
         default: dec_in = 4'd0;
      endcase
   end

   seg7_decoder u_dec (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Glyph for the current scan position
   always_comb begin
      seg_next = SEG_BLANK;
      case (idx)
         ONES: seg_next = dec_seg;
`ifdef PPC_SEG_LEADING_ZERO_EN
         TENS: seg_next = dec_seg;
`else
         TENS: seg_next = tens ? dec_seg : SEG_BLANK;
`endif
         default: seg_next = shadow_dir ? SEG_UP : SEG_DOWN;
      endcase
   end

   // Registered pin drive; anode and segments move together so one digit is lit at a time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
      end else begin
         an_q  <= ~(4'b0001 << idx);
         seg_q <= seg_next;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_ppc_seg_display.sv
// tb/tb_ppc_seg_display.sv - directed table-driven bench for ppc_seg_display with SCAN_DIV=4
module tb_ppc_seg_display;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   int   e;

   ppc_seg_display_if bus ();

   ppc_seg_display #(
      .SCAN_DIV (4),
      .DIV_W    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] val;
      logic       dir;
      logic [6:0] s0;
      logic [6:0] s1;
      logic [6:0] s2;
   } vec_t;

   vec_t vecs [7];

`ifdef PPC_SEG_LEADING_ZERO_EN
   localparam logic [6:0] TENS_LOW = 7'b1000000;
`else
   localparam logic [6:0] TENS_LOW = 7'b1111111;
`endif

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, e);
   endtask

   task automatic go_to(input int t);
      while (e < t) begin
         @(negedge clk);
         e++;
      end
   endtask

   task automatic do_reset(input logic [3:0] v, input logic d);
      bus.out_val   = v;
      bus.direction = d;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      e = 0;
   endtask

   initial begin
      total = 0;
      passed = 0;
      e = 0;
      rst = 1'b1;
      bus.out_val = 4'd0;
      bus.direction = 1'b1;

      vecs[0] = '{4'd7,  1'b1, 7'b1111000, 7'b1111111, 7'b1011100};
      vecs[1] = '{4'd13, 1'b0, 7'b0110000, 7'b1111001, 7'b1100011};
      vecs[2] = '{4'd0,  1'b1, 7'b1000000, TENS_LOW,   7'b1011100};
      vecs[3] = '{4'd10, 1'b0, 7'b1000000, 7'b1111001, 7'b1100011};
      vecs[4] = '{4'd15, 1'b1, 7'b0010010, 7'b1111001, 7'b1011100};
      vecs[5] = '{4'd9,  1'b0, 7'b0010000, TENS_LOW,   7'b1100011};
      vecs[6] = '{4'd3,  1'b1, 7'b0110000, TENS_LOW,   7'b1011100};

      // Reset held
      repeat (3) @(negedge clk);
      chk("rst_an",  {4'b0, bus.an},  8'b0000_1111);
      chk("rst_seg", {1'b0, bus.seg}, 8'b0111_1111);
      chk("rst_dp",  {7'b0, bus.dp},  8'd1);

      // Release: first edge shows digit 0 of the reset shadow, then full scan order
      rst = 1'b0;
      e = 0;
      go_to(1);
      chk("first_seg", {1'b0, bus.seg}, 8'b0100_0000);
      for (int n = 1; n <= 16; n++) begin
         logic [3:0] one;
         one = 4'b0001;
         go_to(n);
         chk("scan_an", {4'b0, bus.an}, {4'b0, ~(one << ((n - 1) / 4))});
         chk("onehot", 8'($countones(~bus.an)), 8'd1);
         chk("dp_off", {7'b0, bus.dp}, 8'd1);
      end

      // Table of values across all four digits
      for (int i = 0; i < 7; i++) begin
         do_reset(vecs[i].val, vecs[i].dir);
         go_to(2);
         chk("v_an0",  {4'b0, bus.an},  8'b0000_1110);
         chk("v_ones", {1'b0, bus.seg}, {1'b0, vecs[i].s0});
         go_to(6);
         chk("v_an1",  {4'b0, bus.an},  8'b0000_1101);
         chk("v_tens", {1'b0, bus.seg}, {1'b0, vecs[i].s1});
         go_to(10);
         chk("v_dirl", {1'b0, bus.seg}, {1'b0, vecs[i].s2});
         go_to(14);
         chk("v_an3",  {4'b0, bus.an},  8'b0000_0111);
         chk("v_dirh", {1'b0, bus.seg}, {1'b0, vecs[i].s2});
      end

      // Value changes 5 -> 12 mid-frame: no tearing until the next frame
      do_reset(4'd5, 1'b1);
      go_to(5);
      chk("tear_an1", {4'b0, bus.an}, 8'b0000_1101);
      bus.out_val = 4'd12;
      go_to(6);
      chk("tear_tens_old", {1'b0, bus.seg}, 8'b0111_1111);
      go_to(8);
      chk("tear_tens_old2", {1'b0, bus.seg}, 8'b0111_1111);
      go_to(10);
      chk("tear_dir", {1'b0, bus.seg}, 8'b0101_1100);
      go_to(16);
      chk("tear_dirh", {1'b0, bus.seg}, 8'b0101_1100);
      go_to(17);
      chk("tear_new_an", {4'b0, bus.an}, 8'b0000_1110);
      chk("tear_new_ones", {1'b0, bus.seg}, 8'b0010_0100);
      go_to(21);
      chk("tear_new_tens", {1'b0, bus.seg}, 8'b0111_1001);

      // Short glitch between captures is never shown
      go_to(22);
      bus.out_val = 4'd0;
      bus.direction = 1'b0;
      go_to(25);
      bus.out_val = 4'd12;
      bus.direction = 1'b1;
      go_to(33);
      chk("glitch_ones", {1'b0, bus.seg}, 8'b0010_0100);
      go_to(37);
      chk("glitch_tens", {1'b0, bus.seg}, 8'b0111_1001);
      go_to(41);
      chk("glitch_dir", {1'b0, bus.seg}, 8'b0101_1100);

      // Asynchronous reset mid-frame at idx 2
      go_to(42);
      chk("mid_an2", {4'b0, bus.an}, 8'b0000_1011);
      bus.out_val = 4'd8;
      bus.direction = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_an",  {4'b0, bus.an},  8'b0000_1111);
      chk("mid_rst_seg", {1'b0, bus.seg}, 8'b0111_1111);
      chk("mid_rst_dp",  {7'b0, bus.dp},  8'd1);
      @(negedge clk);
      rst = 1'b0;
      e = 0;
      go_to(1);
      chk("mid_restart_an", {4'b0, bus.an}, 8'b0000_1110);
      go_to(2);
      chk("mid_restart_ones", {1'b0, bus.seg}, 8'b0000_0000);
      go_to(6);
      chk("mid_restart_tens", {1'b0, bus.seg}, {1'b0, TENS_LOW});
      go_to(10);
      chk("mid_restart_dir", {1'b0, bus.seg}, 8'b0110_0011);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
